// File: rtl/common_param.sv
// Shared ISA constants: R-form opcode and HI/LO funct codes.
// Imported by every EX-stage unit.
package common_param;

  localparam logic [5:0] R_FORM = 6'h00;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1a;
  localparam logic [5:0] DIVU  = 6'h1b;

  function automatic logic is_hilo(
    input logic [5:0] fn
  );
    return (fn == MFHI) || (fn == MTHI) ||
           (fn == MFLO) || (fn == MTLO) ||
           (fn == MULT) || (fn == MULTU) ||
           (fn == DIV)  || (fn == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration.
// Purely combinational; chained STEPS times by ex_muldiv.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_m,
  output logic [XLEN-1:0] o_a,
  output logic [XLEN-1:0] o_b
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_sh;
  logic [XLEN:0] w_dif;
  logic          w_ge;

  // mul: a = upper accumulator, b = multiplier shifting out
  assign w_sum = {1'b0, i_a} +
                 ({1'b0, i_m} & {(XLEN+1){i_b[0]}});

  // div: a = partial remainder, b = dividend in / quotient out
  assign w_sh  = {i_a, i_b[XLEN-1]};
  assign w_ge  = w_sh >= {1'b0, i_m};
  assign w_dif = w_sh - {1'b0, i_m};

  always_comb begin
    o_a = w_sum[XLEN:1];
    o_b = {w_sum[0], i_b[XLEN-1:1]};
    if (i_div) begin
      o_a = w_ge ? w_dif[XLEN-1:0] : w_sh[XLEN-1:0];
      o_b = {i_b[XLEN-2:0], w_ge};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Stalls EX while an iterative op is in flight.
module ex_muldiv
  import common_param::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            InsValid,
  input  logic [31:0]     Ins,
  input  logic [XLEN-1:0] Rdata1,
  input  logic [XLEN-1:0] Rdata2,
  output logic [XLEN-1:0] Result,
  output logic            Stall,
  output logic            Busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int N  = XLEN / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N = CW'(N);
  localparam logic [CW-1:0] CNT_1 = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_m;
  logic            r_div;
  logic            r_qneg;
  logic            r_rneg;
  logic            r_dz;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;

  logic [5:0]      w_fn;
  logic            w_rform;
  logic            w_hilo;
  logic            w_mul_op;
  logic            w_div_op;
  logic            w_signed;
  logic            w_mt_hi;
  logic            w_mt_lo;
  logic            w_mf_hi;
  logic            w_mf_lo;
  logic            w_idle;
  logic            w_accept;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN-1:0] w_a_nx;
  logic [XLEN-1:0] w_b_nx;
  logic [2*XLEN-1:0] w_prod;
  logic            w_unused;

  assign w_fn     = Ins[5:0];
  assign w_rform  = InsValid && (Ins[31:26] == R_FORM);
  assign w_hilo   = w_rform && is_hilo(w_fn);
  assign w_unused = ^Ins[25:6];

  always_comb begin
    w_mul_op = 1'b0;
    w_div_op = 1'b0;
    w_signed = 1'b0;
    w_mt_hi  = 1'b0;
    w_mt_lo  = 1'b0;
    w_mf_hi  = 1'b0;
    w_mf_lo  = 1'b0;
    if (w_rform) begin
      unique case (1'b1)
        (w_fn == MULT):  begin
          w_mul_op = 1'b1;
          w_signed = 1'b1;
        end
        (w_fn == MULTU): w_mul_op = 1'b1;
        (w_fn == DIV):   begin
          w_div_op = 1'b1;
          w_signed = 1'b1;
        end
        (w_fn == DIVU):  w_div_op = 1'b1;
        (w_fn == MTHI):  w_mt_hi  = 1'b1;
        (w_fn == MTLO):  w_mt_lo  = 1'b1;
        (w_fn == MFHI):  w_mf_hi  = 1'b1;
        (w_fn == MFLO):  w_mf_lo  = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_idle   = (r_state == S_IDLE);
  assign Busy     = !w_idle;
  assign Stall    = w_hilo && Busy;
  assign w_accept = w_idle && (w_mul_op || w_div_op);

  assign w_mag1 = (w_signed && Rdata1[XLEN-1]) ?
                  -Rdata1 : Rdata1;
  assign w_mag2 = (w_signed && Rdata2[XLEN-1]) ?
                  -Rdata2 : Rdata2;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    logic [XLEN-1:0] w_ai;
    logic [XLEN-1:0] w_bi;
    logic [XLEN-1:0] w_ao;
    logic [XLEN-1:0] w_bo;
    if (g == 0) begin : g_first
      assign w_ai = r_a;
      assign w_bi = r_b;
    end else begin : g_next
      assign w_ai = g_step[g-1].w_ao;
      assign w_bi = g_step[g-1].w_bo;
    end
    muldiv_step #(
      .XLEN (XLEN)
    ) u_step (
      .i_div (r_div),
      .i_a   (w_ai),
      .i_b   (w_bi),
      .i_m   (r_m),
      .o_a   (w_ao),
      .o_b   (w_bo)
    );
  end

  assign w_a_nx = g_step[STEPS-1].w_ao;
  assign w_b_nx = g_step[STEPS-1].w_bo;
  assign w_prod = r_qneg ? -{r_a, r_b} : {r_a, r_b};

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nx = S_RUN;
      S_RUN:  if (r_cnt == CNT_1) w_state_nx = S_FIX;
      S_FIX:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_div  <= 1'b0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt  <= CNT_N;
            r_a    <= '0;
            r_b    <= w_div_op ? w_mag1 : w_mag2;
            r_m    <= w_div_op ? w_mag2 : w_mag1;
            r_div  <= w_div_op;
            r_qneg <= w_signed &&
                      (Rdata1[XLEN-1] ^ Rdata2[XLEN-1]);
            r_rneg <= w_signed && Rdata1[XLEN-1];
            r_dz   <= (Rdata2 == '0);
          end else if (w_mt_hi) begin
            r_hi <= Rdata1;
          end else if (w_mt_lo) begin
            r_lo <= Rdata1;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nx;
          r_b   <= w_b_nx;
          r_cnt <= r_cnt - CNT_1;
        end
        S_FIX: begin
          if (r_div) begin
            // divide-by-zero keeps the all-ones quotient unsigned
            r_lo <= (r_qneg && !r_dz) ? -r_b : r_b;
            r_hi <= r_rneg ? -r_a : r_a;
          end else begin
            r_hi <= w_prod[2*XLEN-1:XLEN];
            r_lo <= w_prod[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

  always_comb begin
    Result = '0;
    if (w_idle) begin
      if (w_mf_hi)      Result = r_hi;
      else if (w_mf_lo) Result = r_lo;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: STEPS=1 and STEPS=4 builds
// driven in lockstep, checked against an arithmetic reference.
module tb_ex_muldiv;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        InsValid = 1'b0;
  logic [31:0] Ins = '0;
  logic [31:0] Rdata1 = '0;
  logic [31:0] Rdata2 = '0;

  logic [31:0] Result1, HI1, LO1;
  logic        Stall1, Busy1;
  logic [31:0] Result4, HI4, LO4;
  logic        Stall4, Busy4;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(32), .STEPS(1)) u1 (
    .CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Result(Result1),
    .Stall(Stall1), .Busy(Busy1), .HI(HI1), .LO(LO1)
  );

  ex_muldiv #(.XLEN(32), .STEPS(4)) u4 (
    .CLK(CLK), .RST(RST), .InsValid(InsValid), .Ins(Ins),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Result(Result4),
    .Stall(Stall4), .Busy(Busy4), .HI(HI4), .LO(LO4)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ins(input logic [5:0] f);
    return {6'h00, 20'h0, f};
  endfunction

  function automatic void model(input logic [5:0] f,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] hi,
                                output logic [31:0] lo);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    p = '0;
    hi = '0;
    lo = '0;
    case (f)
      F_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        {hi, lo} = p;
      end
      F_MULT: begin
        p = longint'(sa) * longint'(sb);
        {hi, lo} = p;
      end
      F_DIVU: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      F_DIV: begin
        if (b == 0) begin lo = '1; hi = a; end
        else if (a == 32'h8000_0000 && sb == -1) begin
          lo = 32'h8000_0000; hi = 0;
        end else begin
          lo = sa / sb; hi = sa % sb;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int c1, c4;
    c1 = 0;
    c4 = 0;
    Ins = ins(f);
    Rdata1 = a;
    Rdata2 = b;
    InsValid = 1'b1;
    tick();
    InsValid = 1'b0;
    for (int k = 0; k < 100 && (Busy1 || Busy4); k++) begin
      if (Busy1) c1++;
      if (Busy4) c4++;
      tick();
    end
    chk({tag, " busy1"}, 32'(c1), 32'd33);
    chk({tag, " busy4"}, 32'(c4), 32'd9);
    chk({tag, " hi1"}, HI1, ehi);
    chk({tag, " lo1"}, LO1, elo);
    chk({tag, " hi4"}, HI4, ehi);
    chk({tag, " lo4"}, LO4, elo);
  endtask

  initial begin
    logic [31:0] ehi, elo;
    logic [5:0]  f;
    logic [31:0] a, b;
    int n;

    // reset state
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    Ins = ins(F_MFHI);
    InsValid = 1'b1;
    #1;
    chk("rst result", Result1, 32'h0);
    chk("rst stall", {31'h0, Stall1}, 32'h0);
    chk("rst busy", {31'h0, Busy1}, 32'h0);
    chk("rst hi", HI1, 32'h0);
    chk("rst lo", LO1, 32'h0);
    InsValid = 1'b0;
    tick();

    // directed arithmetic
    run_op("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult -3*5", F_MULT, -32'sd3, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div -7/2", F_DIV, -32'sd7, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu /0", F_DIVU, 32'h1234, 32'h0,
           32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div neg/0", F_DIV, -32'sd8, 32'h0,
           32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op("div min/-1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000);
    run_op("divu max/1", F_DIVU, 32'hFFFF_FFFF, 32'h1,
           32'h0, 32'hFFFF_FFFF);
    run_op("multu 7*9", F_MULTU, 32'd7, 32'd9, 32'h0, 32'd63);

    // dependent MFLO stalls until the product lands
    model(F_MULT, 32'h0001_2345, -32'sd7, ehi, elo);
    Ins = ins(F_MULT);
    Rdata1 = 32'h0001_2345;
    Rdata2 = -32'sd7;
    InsValid = 1'b1;
    tick();
    Ins = ins(F_MFLO);
    n = 0;
    for (int k = 0; k < 100 && Stall1; k++) begin
      n++;
      tick();
    end
    chk("mflo stall cycles", 32'(n), 32'd33);
    chk("mflo busy", {31'h0, Busy1}, 32'h0);
    chk("mflo result", Result1, elo);
    chk("mflo result4", Result4, elo);
    InsValid = 1'b0;
    tick();

    // ADD not stalled; stalled MTHI writes only once idle
    Ins = ins(F_DIVU);
    Rdata1 = 32'd100;
    Rdata2 = 32'd7;
    InsValid = 1'b1;
    tick();
    Ins = ins(F_ADD);
    #1;
    chk("add stall", {31'h0, Stall1}, 32'h0);
    chk("add result", Result1, 32'h0);
    chk("add busy", {31'h0, Busy1}, 32'h1);
    Ins = ins(F_MTHI);
    Rdata1 = 32'hDEAD_BEEF;
    for (int k = 0; k < 100 && Busy1; k++) tick();
    chk("mthi held hi", HI1, 32'd2);
    chk("mthi held lo", LO1, 32'd14);
    chk("mthi unstall", {31'h0, Stall1}, 32'h0);
    tick();
    chk("mthi done", HI1, 32'hDEAD_BEEF);
    InsValid = 1'b0;
    tick();

    // reset aborts an in-flight divide
    Ins = ins(F_DIV);
    Rdata1 = -32'sd100;
    Rdata2 = 32'd3;
    InsValid = 1'b1;
    tick();
    InsValid = 1'b0;
    repeat (9) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort busy", {31'h0, Busy1}, 32'h0);
    chk("abort hi", HI1, 32'h0);
    chk("abort lo", LO1, 32'h0);
    repeat (40) tick();
    chk("abort no write", LO1, 32'h0);
    Ins = ins(F_MTHI);
    Rdata1 = 32'hA5A5_A5A5;
    InsValid = 1'b1;
    tick();
    Ins = ins(F_MFHI);
    #1;
    chk("mfhi after mthi", Result1, 32'hA5A5_A5A5);
    chk("mfhi after mthi4", Result4, 32'hA5A5_A5A5);
    InsValid = 1'b0;
    tick();

    // reset wins over a same-cycle accept
    RST = 1'b1;
    Ins = ins(F_MULT);
    Rdata1 = 32'd3;
    Rdata2 = 32'd4;
    InsValid = 1'b1;
    tick();
    RST = 1'b0;
    InsValid = 1'b0;
    chk("rst+accept busy", {31'h0, Busy1}, 32'h0);
    chk("rst+accept busy4", {31'h0, Busy4}, 32'h0);
    tick();

    // random vectors against the reference model
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      if (i % 4 == 3) b = 32'h0;
      if (i % 5 == 4) b = $urandom_range(1, 255);
      model(f, a, b, ehi, elo);
      run_op($sformatf("rand%0d f%h", i, f), f, a, b, ehi, elo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle EX datapath. It executes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It stalls the pipeline while an iterative operation is in flight. Throughput and latency are set by a steps-per-cycle parameter.

## Interface
- XLEN, 32, operand/HI/LO width
- STEPS, 1, shift-add / restoring-divide iterations per clock; legal 1, 2, 4; XLEN % STEPS == 0
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- InsValid  in  1  Ins is a live EX-stage instruction
- Ins  in  32  instruction word; unit reacts only when Ins[31:26]==R_FORM
- Rdata1  in  XLEN  rs operand (dividend / multiplicand / MTHI, MTLO source)
- Rdata2  in  XLEN  rt operand (divisor / multiplier)
- Result  out  XLEN  MFHI/MFLO read data, combinational; 0 for any other instruction
- Stall  out  1  hold EX stage this cycle, combinational
- Busy  out  1  iterative operation in flight, registered
- HI, LO  out  XLEN  architectural registers, registered

## Operation
- HI/LO ops: InsValid, Ins[31:26]==R_FORM and funct ∈ {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO}.
- States: IDLE, RUN, FIX. Busy = (state != IDLE).
- Accept: in IDLE with InsValid and funct ∈ {MULT, MULTU, DIV, DIVU}.
  - Latch operand magnitudes.
  - Latch sign flags: signed ops only; quotient negative iff signs differ; remainder takes the dividend sign.
  - Load counter = XLEN/STEPS; go to RUN.
- RUN: perform STEPS iterations per clock and decrement the counter. When the counter reaches 1, go to FIX on the next edge.
- FIX: apply two's-complement negation per the sign flags, write HI/LO, go to IDLE.
- MULT/MULTU: {HI,LO} = full 2·XLEN product. MULTU is unsigned; MULT is signed.
- DIV/DIVU: LO = quotient truncated toward zero, HI = remainder.
- Divide by zero, all variants: LO = all-ones, HI = Rdata1 unchanged. Still takes full latency.
- Signed DIV of MIN by −1: LO = MIN, HI = 0. No trap.
- MTHI/MTLO in IDLE: write Rdata1 at the clock edge. Single cycle, no Busy.
- MFHI/MFLO in IDLE: Result = HI/LO combinationally, including a value written at the immediately preceding edge.
- Stall = InsValid & HI/LO op & Busy.
  - While stalled, no new accept occurs and MTHI/MTLO do not write.
  - The stalled instruction is re-presented and completes once IDLE.
- Non-HI/LO instructions never stall and never disturb the FSM, even while Busy.
- RST: state = IDLE, HI = LO = 0, Busy = 0, counter = 0. Any in-flight op is aborted with no HI/LO write.

## Timing
- Accept at edge t: Busy = 1 from t+1.
- HI/LO update at edge t + XLEN/STEPS + 1.
  - Default (XLEN=32, STEPS=1): latency 33 cycles after the accept edge.
- Busy = 0 after that edge. A dependent MFHI/MFLO completes in the first IDLE cycle.
- Back-to-back ops: the second op is stalled through FIX and is accepted in the first IDLE cycle. No idle bubble beyond that.
- Outputs after reset: Result 0 unless an MFHI/MFLO is presented (then 0); Stall 0; Busy 0; HI 0; LO 0.
- RST asserted in the same cycle as an accept: reset wins, nothing is accepted.

## Structure
- Shared package/header common_param: R_FORM opcode and funct codes MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- Local constants: the FSM state encoding.
- Sub-module muldiv_step, purely combinational, one iteration, mode input mul/div. The top instantiates STEPS copies chained via generate.
- The top holds the FSM, counter, sign flags, accumulator/remainder registers and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; Busy high exactly 33 cycles.
- MULT −3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x00001234. DIV 0x80000000 / −1 -> LO=0x80000000, HI=0.
- MULT then MFLO on the next cycle -> Stall high until Busy falls; MFLO returns the product in the first IDLE cycle. An ADD presented while Busy is not stalled.
- RST pulsed mid-DIV (cycle 10) -> Busy=0, HI=LO=0 next cycle; a subsequent MTHI 0xA5A5A5A5 then MFHI returns 0xA5A5A5A5.
- STEPS=4 build: MULTU 7 × 9 -> LO=63 after 9 cycles, matching a random-vector reference model.
